uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the data bits per frame.
REQ-002 The block SHALL have parameter BIT_COUNTER_WIDTH, default 3, giving the width of the data-bit index counter.
REQ-003 The block SHALL have parameter CLOCK_COUNTER_WIDTH, default 21, giving the width of the baud-tick counter.
REQ-004 The block SHALL have parameter CLOCKS_PER_BIT, default 434, giving i_clock cycles per serial bit.
REQ-005 The block SHALL have port i_clock, input, 1 bit, the single clock; all state SHALL change only on its rising edge.
REQ-006 The block SHALL have port i_reset, input, 1 bit, the reset; reset is synchronous and active-high.
REQ-007 The block SHALL have port i_RX, input, 1 bit, the asynchronous serial line, idle high.
REQ-008 The block SHALL have port o_data, output, DATA_WIDTH bits, the last correctly framed byte.
REQ-009 The block SHALL have port o_valid, output, 1 bit, a one-cycle pulse when o_data is updated.
REQ-010 The block SHALL have port o_frame_error, output, 1 bit, a one-cycle pulse on a bad stop bit.
REQ-011 The block SHALL have port o_busy, output, 1 bit, high in every state except IDLE.

Function
REQ-012 i_RX SHALL pass through a 2-flop synchronizer; all decisions SHALL use the second flop (rx_s).
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP and BREAK, one-hot or encoded, with no other reachable state.
REQ-014 IDLE: when rx_s=0, the FSM SHALL go to START and clear the tick counter.
REQ-015 START: at tick count CLOCKS_PER_BIT/2-1 (integer division), rx_s=0 SHALL go to DATA with tick and bit counters cleared; rx_s=1 SHALL return to IDLE with no pulse (false start).
REQ-016 DATA: at tick count CLOCKS_PER_BIT-1, rx_s SHALL shift in LSB-first, the bit counter SHALL increment, and the tick counter SHALL clear.
REQ-017 DATA: after the DATA_WIDTH-th sample, the FSM SHALL go to STOP; the bit counter SHALL wrap to 0 without affecting o_data.
REQ-018 STOP: at tick count CLOCKS_PER_BIT-1, rx_s=1 SHALL load the shift register into o_data, pulse o_valid for 1 cycle, and go to IDLE.
REQ-019 STOP: at tick count CLOCKS_PER_BIT-1, rx_s=0 SHALL pulse o_frame_error for 1 cycle, leave o_data unchanged, and go to BREAK.
REQ-020 BREAK: the FSM SHALL stay until rx_s=1, then go to IDLE; a held-low line SHALL NOT produce repeated frames.
REQ-021 o_valid and o_frame_error SHALL never be high in the same cycle.
REQ-022 Latency: o_valid SHALL assert in the cycle after the stop-bit sample edge, about 9.5 bit periods plus 2 synchronizer cycles after the start falling edge.
REQ-023 o_data SHALL hold its value between frames until the next good frame.
REQ-024 A falling edge arriving in the same cycle the FSM enters IDLE from STOP SHALL be detected on the next cycle; back-to-back frames SHALL be received without loss.
REQ-025 The tick counter SHALL be CLOCK_COUNTER_WIDTH bits; CLOCKS_PER_BIT-1 SHALL fit in that width.

Reset
REQ-026 While i_reset=1 at a clock edge: FSM=IDLE; counters and shift register=0; synchronizer flops=1; o_data=0; o_valid=0; o_frame_error=0; o_busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no o_valid or o_frame_error pulse; reception SHALL restart only on a new falling edge after reset release.

Verification
REQ-028 With CLOCKS_PER_BIT=16, send frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1): the bench SHALL see o_data=0xA5 and exactly one o_valid pulse.
REQ-029 A low glitch of 4 cycles on idle i_RX SHALL give a return to IDLE, no o_valid, no o_frame_error, and o_data unchanged.
REQ-030 Send 0x3C with stop bit=0, then hold i_RX low for 40 bit periods: the bench SHALL see one o_frame_error pulse, o_data unchanged, o_busy=1 until i_RX rises, and no further pulses.
REQ-031 Send back-to-back frames 0x00, 0xFF, 0x55 with no idle gap: the bench SHALL see three o_valid pulses with o_data 0x00, 0xFF, 0x55 in order.
REQ-032 Assert i_reset for 1 cycle during DATA bit 3 of 0x81, then send 0x7E: the bench SHALL see no pulse for the aborted frame and o_data=0x7E with a single o_valid.
REQ-033 Sweep the actual bit period ±3% from CLOCKS_PER_BIT=434 with frame 0xC3: the bench SHALL see correct reception at every point.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: 8N1-style serial to parallel with a 2-flop input synchronizer,
// mid-bit sampling, frame-error detection and break handling.
module uart_receiver #(
  parameter int DATA_WIDTH          = 8,
  parameter int BIT_COUNTER_WIDTH   = 3,
  parameter int CLOCK_COUNTER_WIDTH = 21,
  parameter int CLOCKS_PER_BIT      = 434
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_RX,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_error,
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  // Sample points: middle of the start bit, then one full bit period later for each bit.
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] HALF_TICK =
    CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] FULL_TICK =
    CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [BIT_COUNTER_WIDTH-1:0] LAST_BIT =
    BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

  logic                           rx_meta;
  logic                           rx_s;
  state_t                         state_reg, state_next;
  logic [CLOCK_COUNTER_WIDTH-1:0] tick_reg, tick_next;
  logic [BIT_COUNTER_WIDTH-1:0]   bit_reg, bit_next;
  logic [DATA_WIDTH-1:0]          shift_reg, shift_next;
  logic [DATA_WIDTH-1:0]          data_reg, data_next;
  logic                           valid_reg, valid_next;
  logic                           ferr_reg, ferr_next;

  // Two-flop synchronizer; both flops reset to the idle-high line level.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RX;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
    end
  end

  // Next-state logic; pulses default low so they last exactly one cycle.
  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          tick_next  = '0;
        end
      end
      START: begin
        if (tick_reg == HALF_TICK) begin
          if (!rx_s) begin
            state_next = DATA;
            tick_next  = '0;
            bit_next   = '0;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_next = IDLE;
          end
        end else begin
          tick_next = tick_reg + 1'b1;
        end
      end
      DATA: begin
        if (tick_reg == FULL_TICK) begin
          shift_next = {rx_s, shift_reg[DATA_WIDTH-1:1]};
          tick_next  = '0;
          if (bit_reg == LAST_BIT) begin
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          tick_next = tick_reg + 1'b1;
        end
      end
      STOP: begin
        if (tick_reg == FULL_TICK) begin
          tick_next = '0;
          if (rx_s) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end else begin
          tick_next = tick_reg + 1'b1;
        end
      end
      BREAK: begin
        // Wait out a held-low line so it cannot be seen as a new start bit.
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_data        = data_reg;
  assign o_valid       = valid_reg;
  assign o_frame_error = ferr_reg;
  assign o_busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a fast instance (16 clocks/bit) for the
// functional cases and a 434 clocks/bit instance for the baud-tolerance sweep.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

  always #5 clk = ~clk;

  uart_receiver #(.CLOCKS_PER_BIT(16)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_RX(rx_a),
    .o_data(data_a), .o_valid(valid_a), .o_frame_error(ferr_a), .o_busy(busy_a)
  );

  uart_receiver #(.CLOCKS_PER_BIT(434)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_RX(rx_b),
    .o_data(data_b), .o_valid(valid_b), .o_frame_error(ferr_b), .o_busy(busy_b)
  );

  int         checks = 0;
  int         errors = 0;
  int         va_cnt = 0, fa_cnt = 0, vb_cnt = 0, fb_cnt = 0;
  int         overlap = 0;
  time        last_valid_t = 0;
  logic [7:0] qa[$];

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid_a) begin
      va_cnt++;
      qa.push_back(data_a);
      last_valid_t = $time;
    end
    if (ferr_a) fa_cnt++;
    if (valid_b) vb_cnt++;
    if (ferr_b) fb_cnt++;
    if ((valid_a && ferr_a) || (valid_b && ferr_b)) overlap++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic drive(input int sel, input bit v, input int n);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int sel, input logic [7:0] d, input bit stop,
                      input int p, input int idle_bits);
    drive(sel, 1'b0, p);
    for (int i = 0; i < 8; i++) drive(sel, d[i], p);
    drive(sel, stop, p);
    if (idle_bits > 0) drive(sel, 1'b1, idle_bits * p);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];
  int   sweep[7];

  initial begin
    int va0, fa0, vb0, fb0;
    time t0;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
    vecs[4] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    vecs[5] = '{8'h80, 1'b1, 1, 0, 8'h80};
    vecs[6] = '{8'h01, 1'b0, 0, 1, 8'h80};
    sweep   = '{421, 425, 430, 434, 438, 443, 447};

    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data",  int'(data_a), 0);
    check("reset_valid", int'(valid_a), 0);
    check("reset_ferr",  int'(ferr_a), 0);
    check("reset_busy",  int'(busy_a), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Table-driven frames at 16 clocks/bit.
    for (int i = 0; i < 7; i++) begin
      va0 = va_cnt;
      fa0 = fa_cnt;
      t0  = $time;
      send(0, vecs[i].data, vecs[i].stop, 16, 3);
      check($sformatf("vec%0d_valid", i), va_cnt - va0, vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr", i),  fa_cnt - fa0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_data", i),  int'(data_a), int'(vecs[i].exp_data));
      // 2 sync + 1 detect + half bit + 9 bit periods = 155 clocks of 10 time units.
      if (i == 0) check("vec0_latency", int'(last_valid_t - t0), 1550);
    end

    // Short low glitch on the idle line.
    va0 = va_cnt;
    fa0 = fa_cnt;
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 40);
    check("glitch_busy",  int'(busy_a), 0);
    check("glitch_valid", va_cnt - va0, 0);
    check("glitch_ferr",  fa_cnt - fa0, 0);
    check("glitch_data",  int'(data_a), 8'h80);

    // Bad stop bit followed by a line held low for 40 bit periods.
    va0 = va_cnt;
    fa0 = fa_cnt;
    drive(0, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(0, (8'h3C >> i) & 1, 16);
    drive(0, 1'b0, 40 * 16);
    check("break_ferr",  fa_cnt - fa0, 1);
    check("break_valid", va_cnt - va0, 0);
    check("break_data",  int'(data_a), 8'h80);
    check("break_busy",  int'(busy_a), 1);
    drive(0, 1'b1, 5);
    check("break_release_busy", int'(busy_a), 0);
    drive(0, 1'b1, 48);
    check("break_no_more_pulses", (fa_cnt - fa0) + (va_cnt - va0), 1);

    // Back-to-back frames with no idle gap.
    qa.delete();
    send(0, 8'h00, 1'b1, 16, 0);
    send(0, 8'hFF, 1'b1, 16, 0);
    send(0, 8'h55, 1'b1, 16, 3);
    check("b2b_count", qa.size(), 3);
    check("b2b_0", (qa.size() > 0) ? int'(qa[0]) : -1, 8'h00);
    check("b2b_1", (qa.size() > 1) ? int'(qa[1]) : -1, 8'hFF);
    check("b2b_2", (qa.size() > 2) ? int'(qa[2]) : -1, 8'h55);

    // One-cycle reset in the middle of data bit 3 of 0x81; the sender abandons it.
    va0 = va_cnt;
    fa0 = fa_cnt;
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 16);
    drive(0, 1'b0, 16);
    drive(0, 1'b0, 16);
    drive(0, 1'b0, 8);
    rst  = 1'b1;
    rx_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 12 * 16);
    check("abort_valid", va_cnt - va0, 0);
    check("abort_ferr",  fa_cnt - fa0, 0);
    check("abort_data",  int'(data_a), 0);
    check("abort_busy",  int'(busy_a), 0);
    send(0, 8'h7E, 1'b1, 16, 3);
    check("after_abort_valid", va_cnt - va0, 1);
    check("after_abort_data",  int'(data_a), 8'h7E);

    // Baud-rate tolerance sweep (+/-3%) on the 434 clocks/bit instance.
    rx_b = 1'b1;
    for (int i = 0; i < 7; i++) begin
      vb0 = vb_cnt;
      fb0 = fb_cnt;
      send(1, 8'hC3, 1'b1, sweep[i], 2);
      check($sformatf("sweep%0d_pulses", sweep[i]), (vb_cnt - vb0) + 2 * (fb_cnt - fb0), 1);
      check($sformatf("sweep%0d_data", sweep[i]), int'(data_b), 8'hC3);
    end
    check("sweep_idle_busy", int'(busy_b), 0);

    check("valid_ferr_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
